rf_wport_arbiter: RTL and testbench
===================================

// Module: rf_wport_arbiter
// PURPOSE
//  Shares the register file's single write port between the in-order pipeline writeback (WB) stage and a
//  long-latency unit (LU: mult/div, load miss). Buffers LU results in a small queue, bounds LU starvation by
//  requesting a one-cycle WB hold, and keeps a scoreboard of registers with outstanding LU writes so decode
//  can stall on RAW/WAW hazards. Sits between the WB/LU stages and the register file's we/wa/wd port.
// PARAMETERS
//  ADDR_W      5   register address width (32 architectural registers)
//  DATA_W      32  write data width
//  FIFO_DEPTH  2   LU result queue entries (>=2, power of two)
//  STARVE_MAX  8   consecutive blocked cycles before a WB hold is requested (>=2)
// PORTS
//  clk         in   1       single clock; all state updates on posedge
//  rst         in   1       synchronous, active-high reset
//  wb_we       in   1       WB stage write request (never back-pressured)
//  wb_wa       in   ADDR_W  WB destination register
//  wb_wd       in   DATA_W  WB write data
//  wb_hold     out  1       registered; pipeline must present wb_we=0 in any cycle this is high
//  lu_valid    in   1       LU result valid
//  lu_ready    out  1       queue can accept an LU result (= !full)
//  lu_wa       in   ADDR_W  LU destination register
//  lu_wd       in   DATA_W  LU result data
//  iss_valid   in   1       decode issues an LU op reserving iss_wa
//  iss_wa      in   ADDR_W  register reserved by the issuing LU op
//  iss_ready   out  1       combinational: !pending[iss_wa]; issue takes effect only if iss_valid&&iss_ready
//  chk_ra1/2/3 in   ADDR_W  decode source addresses to hazard-check
//  stall       out  1       combinational: pending[] set for any chk_ra*
//  rf_we       out  1       combinational register-file write enable
//  rf_wa       out  ADDR_W  register-file write address
//  rf_wd       out  DATA_W  register-file write data
// BEHAVIOUR
//  - Reset: queue empty, pending=0, starve_cnt=0, wb_hold=0; while rst=1 lu_ready=0, iss_ready=0, rf_we=0.
//  - Port grant per cycle: wb_we=1 -> WB owns port (rf_*=wb_*); else queue non-empty -> head popped (rf_*=head).
//    Neither -> rf_we=0. rf_* are combinational; register file captures on the same posedge.
//  - Address 0: any write to reg 0 drives rf_we=0 but still completes (WB consumed / head popped).
//  - Queue: push when lu_valid&&lu_ready; no bypass, so LU accepted at edge N writes no earlier than cycle N+1.
//    lu_ready depends on full only (push while full refused even if popping that cycle). Push+pop same cycle
//    legal when not full; occupancy unchanged. Pointers wrap modulo FIFO_DEPTH.
//  - Scoreboard pending[2**ADDR_W-1:0]: set at edge on accepted issue with iss_wa!=0; cleared at edge when
//    the head carrying that address is popped. Set and clear of same reg same edge: set wins. pending[0]
//    always 0. LU results for non-pending addresses are written normally and clear nothing extra.
//  - Starvation: starve_cnt increments each cycle queue non-empty and not popped; clears on pop or empty.
//    When starve_cnt==STARVE_MAX-1 and still blocked, wb_hold=1 next cycle (exactly one cycle); queue pops
//    in that cycle, starve_cnt->0. wb_we=1 during wb_hold is a protocol error: WB still wins, sim assertion fires.
//  - Hazard timing: a pending bit cleared at edge N deasserts stall in cycle N+1 (data already in regfile).
//  - Reset mid-operation: queued results and reservations are discarded; no write issued in reset cycle.
// STRUCTURE
//  - Shared package rf_ctrl_pkg: ADDR_W, DATA_W, REG_ZERO=0, REG_SP=29, typedef rf_wr_t {we, wa, wd}.
//  - One sub-module: rf_wq_fifo (FIFO_DEPTH-entry synchronous FIFO, push/pop/full/empty, head output).
//  - Top holds grant mux, scoreboard vector, starvation counter and wb_hold flop.
// TESTING
//  1 Idle WB: iss_wa=5 issue, then lu_valid wa=5 wd=0xDEAD -> next cycle rf_we=1 wa=5 wd=0xDEAD; stall on
//    chk_ra1=5 high from issue until cycle after write, then low.
//  2 Conflict: wb_we=1 wa=3 and queued LU wa=7 same cycle -> rf_wa=3 this cycle, rf_wa=7 next idle cycle.
//  3 Starvation: queue holds wa=9, wb_we=1 every cycle -> wb_hold=1 exactly in cycle STARVE_MAX+1 after push
//    (bench drops wb_we), rf_wa=9 that cycle, wb_hold=0 after.
//  4 Full/back-pressure: two LU pushes with WB busy -> lu_ready=0; third lu_valid held, accepted after a pop;
//    all three writes appear in push order.
//  5 Reg zero + WAW: LU write wa=0 -> rf_we=0, queue pops; second issue to pending wa=5 -> iss_ready=0, set
//    only after clear; same-edge clear+issue of wa=5 leaves pending[5]=1.
//  6 Reset mid-op: rst with 2 queued entries and pending[5]=1 -> next cycle empty, pending=0, rf_we=0.

Source files
------------

// File: rtl/rf_ctrl_pkg.sv
// rtl/rf_ctrl_pkg.sv - shared register-file control widths, register names and write record
package rf_ctrl_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int REG_ZERO = 0;
    localparam int REG_SP   = 29;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
    } rf_wr_t;

endpackage

// File: rtl/rf_wq_fifo.sv
// rtl/rf_wq_fifo.sv - small synchronous FIFO holding long-latency results awaiting the write port
module rf_wq_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/rf_wport_arbiter.sv
// rtl/rf_wport_arbiter.sv - shares the register-file write port between WB and the long-latency unit
module rf_wport_arbiter #(
    parameter int ADDR_W     = rf_ctrl_pkg::ADDR_W,
    parameter int DATA_W     = rf_ctrl_pkg::DATA_W,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_wa,
    input  logic [DATA_W-1:0] wb_wd,
    output logic              wb_hold,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [ADDR_W-1:0] lu_wa,
    input  logic [DATA_W-1:0] lu_wd,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_wa,
    output logic              iss_ready,
    input  logic [ADDR_W-1:0] chk_ra1,
    input  logic [ADDR_W-1:0] chk_ra2,
    input  logic [ADDR_W-1:0] chk_ra3,
    output logic              stall,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wa,
    output logic [DATA_W-1:0] rf_wd
);

    import rf_ctrl_pkg::*;

    localparam int FW    = ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(STARVE_MAX);

    logic [2**ADDR_W-1:0] pending;
    logic [2**ADDR_W-1:0] pending_nxt;
    logic [FW-1:0]        head;
    logic [ADDR_W-1:0]    head_wa;
    logic [DATA_W-1:0]    head_wd;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 issue;
    logic                 blocked;
    logic [CNT_W-1:0]     starve_cnt;

    rf_wq_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_wq (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({lu_wa, lu_wd}),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    assign {head_wa, head_wd} = head;

    // Acceptance looks at full only: a pop in the same cycle does not free a slot early
    assign lu_ready  = !rst && !full;
    assign push      = lu_valid && lu_ready;
    assign pop       = !rst && !wb_we && !empty;
    assign blocked   = !empty && !pop;

    assign iss_ready = !rst && !pending[iss_wa];
    assign issue     = iss_valid && iss_ready && (iss_wa != ADDR_W'(REG_ZERO));
    assign stall     = pending[chk_ra1] | pending[chk_ra2] | pending[chk_ra3];

    // Writes to register zero still consume their slot but never reach the file
    always_comb begin
        rf_we = 1'b0;
        rf_wa = head_wa;
        rf_wd = head_wd;
        if (wb_we) begin
            rf_wa = wb_wa;
            rf_wd = wb_wd;
            rf_we = !rst && (wb_wa != ADDR_W'(REG_ZERO));
        end else begin
            rf_we = pop && (head_wa != ADDR_W'(REG_ZERO));
        end
    end

    // A new reservation landing on the edge that retires the old one must survive
    always_comb begin
        pending_nxt = pending;
        if (pop)   pending_nxt[head_wa] = 1'b0;
        if (issue) pending_nxt[iss_wa]  = 1'b1;
        pending_nxt[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= '0;
            starve_cnt <= '0;
            wb_hold    <= 1'b0;
        end else begin
            pending <= pending_nxt;
            wb_hold <= blocked && (starve_cnt == CNT_W'(STARVE_MAX - 1));
            if (!blocked) begin
                starve_cnt <= '0;
            end else if (starve_cnt != CNT_W'(STARVE_MAX - 1)) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wb_hold) assert (!wb_we);
    end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// tb/tb_rf_wport_arbiter.sv - scoreboard bench for the register-file write-port arbiter
module tb_rf_wport_arbiter;
    import rf_ctrl_pkg::*;

    localparam int STARVE_MAX = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_wa;
    logic [DATA_W-1:0] wb_wd;
    logic              wb_hold;
    logic              lu_valid;
    logic              lu_ready;
    logic [ADDR_W-1:0] lu_wa;
    logic [DATA_W-1:0] lu_wd;
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_wa;
    logic              iss_ready;
    logic [ADDR_W-1:0] chk_ra1;
    logic [ADDR_W-1:0] chk_ra2;
    logic [ADDR_W-1:0] chk_ra3;
    logic              stall;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_wa;
    logic [DATA_W-1:0] rf_wd;

    int checks = 0;
    int errors = 0;
    rf_wr_t exp_q[$];

    rf_wport_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (2),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_we     (wb_we),
        .wb_wa     (wb_wa),
        .wb_wd     (wb_wd),
        .wb_hold   (wb_hold),
        .lu_valid  (lu_valid),
        .lu_ready  (lu_ready),
        .lu_wa     (lu_wa),
        .lu_wd     (lu_wd),
        .iss_valid (iss_valid),
        .iss_wa    (iss_wa),
        .iss_ready (iss_ready),
        .chk_ra1   (chk_ra1),
        .chk_ra2   (chk_ra2),
        .chk_ra3   (chk_ra3),
        .stall     (stall),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        wb_we = 1'b0; wb_wa = '0; wb_wd = '0;
        lu_valid = 1'b0; lu_wa = '0; lu_wd = '0;
        iss_valid = 1'b0; iss_wa = '0;
    endtask

    task automatic expw(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        exp_q.push_back('{we: 1'b1, wa: a, wd: d});
    endtask

    // Monitor: every register-file write must match the next expected write in order
    always @(negedge clk) begin
        rf_wr_t e;
        if (rf_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: actual wa=%0d wd=%0h expected no write", rf_wa, rf_wd);
            end else begin
                e = exp_q.pop_front();
                chk("write_wa", 32'(rf_wa), 32'(e.wa));
                chk("write_wd", rf_wd, e.wd);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        idle;
        chk_ra1 = '0; chk_ra2 = '0; chk_ra3 = '0;
        rst = 1'b1;
        tick; tick;

        // Requests during reset are ignored
        wb_we = 1'b1; wb_wa = 3; wb_wd = 32'h1;
        lu_valid = 1'b1; lu_wa = 4; lu_wd = 32'h2;
        iss_valid = 1'b1; iss_wa = 6;
        #1;
        chk("rst_rf_we", 32'(rf_we), 0);
        chk("rst_lu_ready", 32'(lu_ready), 0);
        chk("rst_iss_ready", 32'(iss_ready), 0);
        tick;
        rst = 1'b0; idle; chk_ra1 = 5; chk_ra2 = 6;
        #1;
        chk("init_lu_ready", 32'(lu_ready), 1);
        chk("init_iss_ready", 32'(iss_ready), 1);
        chk("init_wb_hold", 32'(wb_hold), 0);
        chk("init_stall", 32'(stall), 0);
        chk("init_rf_we", 32'(rf_we), 0);
        tick;
        chk_ra2 = '0;

        // 1: issue, LU result, stall window
        iss_valid = 1'b1; iss_wa = 5;
        #1 chk("t1_stall_before", 32'(stall), 0);
        tick;
        idle; lu_valid = 1'b1; lu_wa = 5; lu_wd = 32'hDEAD; expw(5, 32'hDEAD);
        #1 chk("t1_stall_pending", 32'(stall), 1);
        tick;
        idle;
        #1;
        chk("t1_rf_we", 32'(rf_we), 1);
        chk("t1_rf_wa", 32'(rf_wa), 5);
        chk("t1_stall_write_cycle", 32'(stall), 1);
        tick;
        #1;
        chk("t1_stall_cleared", 32'(stall), 0);
        chk("t1_rf_we_after", 32'(rf_we), 0);
        tick;

        // 2: WB wins over a queued LU result
        wb_we = 1'b1; wb_wa = 3; wb_wd = 32'h33; expw(3, 32'h33);
        lu_valid = 1'b1; lu_wa = 7; lu_wd = 32'h77;
        #1 chk("t2_rf_wa_wb", 32'(rf_wa), 3);
        tick;
        lu_valid = 1'b0; wb_wa = 4; wb_wd = 32'h44; expw(4, 32'h44);
        #1 chk("t2_rf_wa_wb2", 32'(rf_wa), 4);
        tick;
        idle; expw(7, 32'h77);
        #1 chk("t2_rf_wa_lu", 32'(rf_wa), 7);
        tick;

        // 3: starvation forces exactly one hold cycle
        for (int k = 0; k <= STARVE_MAX; k++) begin
            wb_we = 1'b1; wb_wa = 1; wb_wd = 32'(32'h100 + k);
            lu_valid = (k == 0); lu_wa = 9; lu_wd = 32'h99;
            expw(1, 32'(32'h100 + k));
            #1 chk("t3_no_hold", 32'(wb_hold), 0);
            tick;
        end
        idle; expw(9, 32'h99);
        #1;
        chk("t3_hold", 32'(wb_hold), 1);
        chk("t3_rf_we", 32'(rf_we), 1);
        chk("t3_rf_wa", 32'(rf_wa), 9);
        tick;
        #1 chk("t3_hold_after", 32'(wb_hold), 0);
        tick;

        // 4: full queue back-pressure, in-order drain
        wb_we = 1'b1; wb_wa = 2; wb_wd = 32'h200; expw(2, 32'h200);
        lu_valid = 1'b1; lu_wa = 10; lu_wd = 32'hA0;
        #1 chk("t4_ready_0", 32'(lu_ready), 1);
        tick;
        wb_wd = 32'h201; expw(2, 32'h201); lu_wa = 11; lu_wd = 32'hB0;
        #1 chk("t4_ready_1", 32'(lu_ready), 1);
        tick;
        wb_wd = 32'h202; expw(2, 32'h202); lu_wa = 12; lu_wd = 32'hC0;
        #1 chk("t4_full", 32'(lu_ready), 0);
        tick;
        wb_we = 1'b0; expw(10, 32'hA0);
        #1;
        chk("t4_full_while_pop", 32'(lu_ready), 0);
        chk("t4_rf_wa_10", 32'(rf_wa), 10);
        tick;
        expw(11, 32'hB0);
        #1;
        chk("t4_ready_after_pop", 32'(lu_ready), 1);
        chk("t4_rf_wa_11", 32'(rf_wa), 11);
        tick;
        idle; expw(12, 32'hC0);
        #1 chk("t4_rf_wa_12", 32'(rf_wa), 12);
        tick;
        #1 chk("t4_drained", 32'(rf_we), 0);
        tick;

        // 5: register zero, WAW blocking, same-edge clear and set
        lu_valid = 1'b1; lu_wa = 0; lu_wd = 32'h55;
        tick;
        idle;
        #1 chk("t5_zero_rf_we", 32'(rf_we), 0);
        tick;
        lu_valid = 1'b1; lu_wa = 8; lu_wd = 32'h88; expw(8, 32'h88);
        tick;
        idle;
        #1 chk("t5_after_zero_wa", 32'(rf_wa), 8);
        tick;
        iss_valid = 1'b1; iss_wa = 5;
        #1 chk("t5_issue_ready", 32'(iss_ready), 1);
        tick;
        lu_valid = 1'b1; lu_wa = 5; lu_wd = 32'h5A; expw(5, 32'h5A);
        #1 chk("t5_waw_blocked", 32'(iss_ready), 0);
        tick;
        lu_valid = 1'b0;
        #1;
        chk("t5_waw_blocked_pop", 32'(iss_ready), 0);
        chk("t5_pop_wa", 32'(rf_wa), 5);
        chk("t5_stall_pop", 32'(stall), 1);
        tick;
        iss_valid = 1'b0; lu_valid = 1'b1; lu_wa = 5; lu_wd = 32'h5B; expw(5, 32'h5B);
        #1;
        chk("t5_ready_after_clear", 32'(iss_ready), 1);
        chk("t5_stall_clear", 32'(stall), 0);
        tick;
        lu_valid = 1'b0; iss_valid = 1'b1; iss_wa = 5;
        #1;
        chk("t5_same_edge_ready", 32'(iss_ready), 1);
        chk("t5_same_edge_wa", 32'(rf_wa), 5);
        tick;
        idle; iss_wa = 5;
        #1;
        chk("t5_set_wins_stall", 32'(stall), 1);
        chk("t5_set_wins_ready", 32'(iss_ready), 0);
        tick;

        // 6: reset with two queued entries and pending[5]
        wb_we = 1'b1; wb_wa = 2; wb_wd = 32'h300; expw(2, 32'h300);
        lu_valid = 1'b1; lu_wa = 13; lu_wd = 32'hD0;
        tick;
        wb_wd = 32'h301; expw(2, 32'h301); lu_wa = 14; lu_wd = 32'hE0;
        #1 chk("t6_ready_second", 32'(lu_ready), 1);
        tick;
        idle; rst = 1'b1;
        #1 chk("t6_rst_rf_we", 32'(rf_we), 0);
        tick;
        rst = 1'b0; iss_wa = 5;
        #1;
        chk("t6_empty_rf_we", 32'(rf_we), 0);
        chk("t6_stall", 32'(stall), 0);
        chk("t6_lu_ready", 32'(lu_ready), 1);
        chk("t6_iss_ready", 32'(iss_ready), 1);
        tick;
        #1 chk("t6_still_empty", 32'(rf_we), 0);
        tick;
        tick;
        @(negedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
